mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_tag_table.sv | 46 ++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus, tag-table and arbiter state types for the memory arbiter.
// Package sys_defs; the optional feature is selected by MEM_ARB_STARVE_EN.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } ARB_STATE;

endpackage

// File: rtl/mem_arbiter_tag_table.sv
// Outstanding-load tag table: tags 1..15 map to the requester owning them.
// Allocation wins over a same-cycle clear of the same tag.
module mem_tag_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  logic [3:0] alloc_tag,
  input  MEM_OWNER   alloc_owner,
  input  logic       clear_en,
  input  logic [3:0] lookup_tag,
  output logic       lookup_valid,
  output MEM_OWNER   lookup_owner
);

  MEM_TAG_ENTRY table_q [1:15];

  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWN_ICACHE;
    if (lookup_tag != 4'd0) begin
      lookup_valid = table_q[lookup_tag].valid;
      lookup_owner = table_q[lookup_tag].owner;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 16; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      if (clear_en && lookup_tag != 4'd0) begin
        table_q[lookup_tag].valid <= 1'b0;
      end
      if (alloc_en && alloc_tag != 4'd0) begin
        table_q[alloc_tag] <= MEM_TAG_ENTRY'{
          valid: 1'b1,
          owner: alloc_owner
        };
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter (icache/dcache) with tag-based return routing.
// Define MEM_ARB_STARVE_EN to enable the icache anti-starvation counter.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int MEM_ARB_STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,
  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      arb2icache_response,
  output logic [3:0]      arb2icache_tag,
  output logic [63:0]     arb2icache_data,
  output logic [3:0]      arb2dcache_response,
  output logic [3:0]      arb2dcache_tag,
  output logic [63:0]     arb2dcache_data,
  output logic            icache_grant,
  output logic            dcache_grant,
  output logic            arb_tag_err
);

  ARB_STATE state, state_nxt;
  logic     i_req, d_req;
  logic     i_gnt, d_gnt;
  logic     force_i;
  logic     load_gnt, alloc_en;
  logic     tag_valid, hit, err_q;
  MEM_OWNER tag_owner, alloc_owner;

  assign i_req = icache2arb_command != BUS_NONE;
  assign d_req = dcache2arb_command != BUS_NONE;

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  localparam logic [3:0] LIMIT = 4'(MEM_ARB_STARVE_LIMIT);

  assign force_i = (state == IDLE) && i_req &&
                   (starve_cnt == LIMIT);

  // Saturates at the limit so a long dcache hold cannot skip past it.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (i_req && !i_gnt) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  logic [3:0] unused_limit;
  assign unused_limit = 4'(MEM_ARB_STARVE_LIMIT);
  assign force_i = 1'b0;
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state == HOLD_I && i_req) begin
        i_gnt = 1'b1;
      end else if (state == HOLD_D && d_req) begin
        d_gnt = 1'b1;
      end else if (force_i) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  assign icache_grant = i_gnt;
  assign dcache_grant = d_gnt;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (i_gnt) begin
      proc2mem_command = icache2arb_command;
      proc2mem_addr    = icache2arb_addr;
    end else if (d_gnt) begin
      proc2mem_command = dcache2arb_command;
      proc2mem_addr    = dcache2arb_addr;
      proc2mem_data    = dcache2arb_data;
    end
  end

  assign arb2icache_response =
    i_gnt ? mem2proc_response : 4'd0;
  assign arb2dcache_response =
    d_gnt ? mem2proc_response : 4'd0;

  always_comb begin
    state_nxt = IDLE;
    if (mem2proc_response == 4'd0) begin
      if (i_gnt) begin
        state_nxt = HOLD_I;
      end else if (d_gnt) begin
        state_nxt = HOLD_D;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign load_gnt =
    (i_gnt && icache2arb_command == BUS_LOAD) ||
    (d_gnt && dcache2arb_command == BUS_LOAD);
  assign alloc_en    = load_gnt && mem2proc_response != 4'd0;
  assign alloc_owner = d_gnt ? OWN_DCACHE : OWN_ICACHE;

  mem_tag_table u_tags (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (alloc_owner),
    .clear_en     (hit),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (tag_valid),
    .lookup_owner (tag_owner)
  );

  assign hit = !reset && mem2proc_tag != 4'd0 && tag_valid;

  always_comb begin
    arb2icache_tag  = 4'd0;
    arb2icache_data = '0;
    arb2dcache_tag  = 4'd0;
    arb2dcache_data = '0;
    if (hit && tag_owner == OWN_ICACHE) begin
      arb2icache_tag  = mem2proc_tag;
      arb2icache_data = mem2proc_data;
    end else if (hit) begin
      arb2dcache_tag  = mem2proc_tag;
      arb2dcache_data = mem2proc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (mem2proc_tag != 4'd0 && !tag_valid) begin
      err_q <= 1'b1;
    end
  end

  assign arb_tag_err = err_q && !reset;

endmodule
